// File: rtl/sobel_pkg.sv
// Shared types and default constants for the Sobel result-to-UART pacing path.
package sobel_pkg;

    // Default clock and UART rate; the scheduler derives its frame gap from these.
    localparam int CLK_FREQ_DEF  = 50_000_000;
    localparam int UART_BPS_DEF  = 9600;

    // Result bytes per image: the 98x98 interior of a 100x100 input.
    localparam int FRAME_LEN_DEF = 9604;

    typedef logic [7:0] byte_t;

    // Launch scheduler states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/sobel_tx_fifo.sv
// Small show-ahead FIFO buffering Sobel result bytes ahead of the UART.
// The head entry is always visible on rd_data. A write into a full FIFO
// is still accepted when a read happens in the same cycle.
module sobel_tx_fifo
    import sobel_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  byte_t                       wr_data,
    input  logic                        rd_en,
    output byte_t                       rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    byte_t          mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    level_q;
    logic           do_wr;
    logic           do_rd;

    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/sobel_tx_sched.sv
// Paces the bursty Sobel result stream into uart_tx, which has no ready
// signal: bytes are queued and launched one per UART frame time, with a
// per-image byte counter, a frame-complete pulse and a sticky drop flag.
module sobel_tx_sched
    import sobel_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEF,
    parameter int UART_BPS   = UART_BPS_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        pi_flag,
    input  byte_t                       pi_data,
    output logic                        po_flag,
    output byte_t                       po_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        frame_done,
    output logic                        busy
);

    // Ten UART bits plus one bit of guard time after each launch.
    localparam int GAP_CYCLES = (CLK_FREQ / UART_BPS) * 11;
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int FW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

    state_t         state_q, state_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
    logic           launch;

    logic           po_flag_q;
    byte_t          po_data_q;
    logic           overflow_q;
    logic           frame_done_q;
    logic           busy_q;

    byte_t          fifo_head;
    logic           fifo_full;
    logic           fifo_empty;

    sobel_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (pi_flag),
        .wr_data (pi_data),
        .rd_en   (launch),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Next-state logic: launch a queued byte, then sit out one UART frame.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        frame_cnt_d = frame_cnt_q;
        launch      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                launch      = 1'b1;
                gap_d       = GAP_LOAD;
                state_d     = WAIT;
                frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FW'(1);
            end
            WAIT: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, gap timer and frame position registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Registered outputs: launch strobe with its byte, frame pulse, drop flag, activity.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            po_flag_q    <= 1'b0;
            po_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            po_flag_q    <= launch;
            frame_done_q <= launch && (frame_cnt_q == FRAME_LAST);
            if (launch) begin
                po_data_q <= fifo_head;
            end
            // A pop in the same cycle frees a slot, so only a non-launch cycle drops.
            if (pi_flag && fifo_full && !launch) begin
                overflow_q <= 1'b1;
            end
            busy_q <= (state_q != IDLE) || !fifo_empty;
        end
    end

    assign po_flag    = po_flag_q;
    assign po_data    = po_data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule
